// File: rtl/ps2_rxframe.sv
// PS/2 device-to-host frame receiver: sync, clock deglitch, 11-bit deserialise, E0/F0 prefix folding.
// Optional saturating error counter on err_cnt when PS2_RX_ERRCNT_EN is defined.
`timescale 1ns/1ps
module ps2_rxframe #(
    parameter int CLK_FREQ   = 28_000_000,
    parameter int TIMEOUT_US = 200,
    parameter int FILTER_LEN = 8
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic [7:0] code,
    output logic       code_ext,
    output logic       code_release,
    output logic       code_valid,
    output logic       frame_err,
    output logic       busy
`ifdef PS2_RX_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam int TIMEOUT_CYCLES = CLK_FREQ / 1_000_000 * TIMEOUT_US;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    logic                  clk_meta, clk_sync;
    logic                  dat_meta, dat_sync;
    logic [FILTER_LEN-1:0] hist;
    logic                  filt;
    logic                  fall;

    logic [1:0]    state, state_nxt;
    logic [2:0]    bitcnt, bitcnt_nxt;
    logic [7:0]    sr, sr_nxt;
    logic          par, par_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          err_nxt;
    logic          acc_nxt;
    logic          ext_pend, rel_pend;

    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
            hist     <= '1;
            filt     <= 1'b1;
            fall     <= 1'b0;
        end else begin
            clk_meta <= ps2_clk_in;
            clk_sync <= clk_meta;
            dat_meta <= ps2_dat_in;
            dat_sync <= dat_meta;
            hist     <= {hist[FILTER_LEN-2:0], clk_sync};
            // Filtered clock only moves on a unanimous window; fall marks the 1->0 move.
            if (hist == '0) begin
                filt <= 1'b0;
            end else if (hist == '1) begin
                filt <= 1'b1;
            end
            fall <= filt && (hist == '0);
        end
    end

    // cnt holds cycles elapsed since the last fall while a frame is open.
    always_comb begin
        state_nxt  = state;
        bitcnt_nxt = bitcnt;
        sr_nxt     = sr;
        par_nxt    = par;
        cnt_nxt    = cnt;
        err_nxt    = 1'b0;
        acc_nxt    = 1'b0;
        if (fall) begin
            cnt_nxt = CNT_ONE;
            case (state)
                ST_IDLE: begin
                    if (!dat_sync) begin
                        state_nxt  = ST_DATA;
                        bitcnt_nxt = 3'd0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                ST_DATA: begin
                    sr_nxt     = {dat_sync, sr[7:1]};
                    bitcnt_nxt = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        state_nxt = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_nxt   = dat_sync;
                    state_nxt = ST_STOP;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    if (dat_sync && (^{sr, par})) begin
                        acc_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            endcase
        end else if (state != ST_IDLE) begin
            if (cnt == CNT_LAST) begin
                state_nxt = ST_IDLE;
                err_nxt   = 1'b1;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + CNT_ONE;
            end
        end else begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            bitcnt       <= 3'd0;
            sr           <= 8'h00;
            par          <= 1'b0;
            cnt          <= '0;
            ext_pend     <= 1'b0;
            rel_pend     <= 1'b0;
            code         <= 8'h00;
            code_ext     <= 1'b0;
            code_release <= 1'b0;
            code_valid   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            bitcnt     <= bitcnt_nxt;
            sr         <= sr_nxt;
            par        <= par_nxt;
            cnt        <= cnt_nxt;
            frame_err  <= err_nxt;
            code_valid <= 1'b0;
            if (err_nxt) begin
                ext_pend <= 1'b0;
                rel_pend <= 1'b0;
            end else if (acc_nxt) begin
                if (sr == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else if (sr == 8'hF0) begin
                    rel_pend <= 1'b1;
                end else begin
                    code         <= sr;
                    code_ext     <= ext_pend;
                    code_release <= rel_pend;
                    code_valid   <= 1'b1;
                    ext_pend     <= 1'b0;
                    rel_pend     <= 1'b0;
                end
            end
        end
    end

    assign busy = (state != ST_IDLE);

`ifdef PS2_RX_ERRCNT_EN
    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            err_cnt <= 8'h00;
        end else if (err_nxt && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end
`endif

    property p_strobe_excl;
        @(posedge clk28) disable iff (!rst_n) !(code_valid && frame_err);
    endproperty
    a_strobe_excl: assert property (p_strobe_excl);

endmodule

// File: tb/tb_ps2_rxframe.sv
// Bench for ps2_rxframe: directed PS/2 frames plus random frame mixes against a byte-level event model.
`timescale 1ns/1ps
module tb_ps2_rxframe;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT_CYCLES = 5600;
    // raw pin fall -> strobe: 2 sync + FILTER_LEN window + filtered/fall reg + output reg
    localparam int LAT = FILTER_LEN + 4;
    localparam int HALF = 30;
    localparam int HALF_60US = 840;

    logic       clk28 = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk_in = 1'b1;
    logic       ps2_dat_in = 1'b1;
    logic [7:0] code;
    logic       code_ext, code_release, code_valid, frame_err, busy;
`ifdef PS2_RX_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    ps2_rxframe dut (
        .clk28        (clk28),
        .rst_n        (rst_n),
        .ps2_clk_in   (ps2_clk_in),
        .ps2_dat_in   (ps2_dat_in),
        .code         (code),
        .code_ext     (code_ext),
        .code_release (code_release),
        .code_valid   (code_valid),
        .frame_err    (frame_err),
        .busy         (busy)
`ifdef PS2_RX_ERRCNT_EN
        ,
        .err_cnt      (err_cnt)
`endif
    );

    always #5 clk28 = ~clk28;

    typedef struct {
        bit         err;
        logic [7:0] c;
        logic       e;
        logic       r;
        int         t;
    } ev_t;

    ev_t  got[$];
    ev_t  exp_q[$];
    int   cyc = 0;
    int   last_fall = 0;
    int   total = 0;
    int   bad = 0;
    int   n_err = 0;
    logic ext_m = 1'b0;
    logic rel_m = 1'b0;
    logic [7:0] last_code = 8'h00;

    always @(posedge clk28) cyc = cyc + 1;

    always @(negedge clk28) begin
        if (code_valid || frame_err) begin
            ev_t ev;
            total = total + 1;
            assert (!(code_valid && frame_err)) else begin
                bad = bad + 1;
                $error("FAIL excl cyc=%0d valid=%b err=%b required not both", cyc, code_valid, frame_err);
            end
            ev.err = frame_err;
            ev.c = code;
            ev.e = code_ext;
            ev.r = code_release;
            ev.t = cyc;
            got.push_back(ev);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total = total + 1;
        assert (obs === expv) else begin
            bad = bad + 1;
            $error("FAIL %s got=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Byte-level protocol model: what one received frame should produce.
    task automatic model_frame(input logic [7:0] b, input bit good, input int tf);
        ev_t ev;
        if (!good) begin
            ev.err = 1'b1; ev.c = 8'h00; ev.e = 1'b0; ev.r = 1'b0; ev.t = tf + LAT;
            exp_q.push_back(ev);
            n_err = n_err + 1;
            ext_m = 1'b0;
            rel_m = 1'b0;
        end else if (b == 8'hE0) begin
            ext_m = 1'b1;
        end else if (b == 8'hF0) begin
            rel_m = 1'b1;
        end else begin
            ev.err = 1'b0; ev.c = b; ev.e = ext_m; ev.r = rel_m; ev.t = tf + LAT;
            exp_q.push_back(ev);
            last_code = b;
            ext_m = 1'b0;
            rel_m = 1'b0;
        end
    endtask

    task automatic ps2_bit(input logic b, input int half, input bit glitch);
        @(negedge clk28);
        ps2_dat_in = b;
        if (glitch) begin
            repeat (half / 2) @(negedge clk28);
            ps2_clk_in = 1'b0;
            repeat (3) @(negedge clk28);
            ps2_clk_in = 1'b1;
            repeat (half / 2) @(negedge clk28);
        end else begin
            repeat (half) @(negedge clk28);
        end
        ps2_clk_in = 1'b0;
        last_fall = cyc;
        repeat (half) @(negedge clk28);
        ps2_clk_in = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bp, input bit bs);
        return {~bs, (~^b) ^ bp, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit bp, input bit bs, input int half, input int gbit);
        logic [10:0] f;
        f = mk_frame(b, bp, bs);
        for (int i = 0; i < 11; i++) ps2_bit(f[i], half, i == gbit);
        model_frame(b, !bp && !bs, last_fall);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        logic [10:0] f;
        f = mk_frame(b, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(f[i], HALF, 1'b0);
    endtask

    task automatic check_events(input string tag);
        int n;
        repeat (LAT + 4) @(negedge clk28);
        chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_kind%0d", tag, i), 32'(got[i].err), 32'(exp_q[i].err));
            chk($sformatf("%s_time%0d", tag, i), 32'(got[i].t), 32'(exp_q[i].t));
            if (!exp_q[i].err) begin
                chk($sformatf("%s_code%0d", tag, i), 32'(got[i].c), 32'(exp_q[i].c));
                chk($sformatf("%s_ext%0d", tag, i), 32'(got[i].e), 32'(exp_q[i].e));
                chk($sformatf("%s_rel%0d", tag, i), 32'(got[i].r), 32'(exp_q[i].r));
            end
        end
        chk({tag, "_hold"}, 32'(code), 32'(last_code));
        got.delete();
        exp_q.delete();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_code"}, 32'(code), 32'h00);
        chk({tag, "_ext"}, 32'(code_ext), 32'h0);
        chk({tag, "_rel"}, 32'(code_release), 32'h0);
        chk({tag, "_valid"}, 32'(code_valid), 32'h0);
        chk({tag, "_err"}, 32'(frame_err), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    task automatic apply_reset();
        @(negedge clk28);
        rst_n = 1'b0;
        repeat (4) @(negedge clk28);
        ext_m = 1'b0;
        rel_m = 1'b0;
        last_code = 8'h00;
        n_err = 0;
    endtask

    initial begin
        ev_t ev;
        apply_reset();
        chk_reset_state("reset");
        got.delete();
        rst_n = 1'b1;
        repeat (5) @(negedge clk28);

        // single 0x1C frame at a 60 us PS/2 clock period
        send_frame(8'h1C, 1'b0, 1'b0, HALF_60US, -1);
        check_events("t1");

        send_frame(8'hF0, 1'b0, 1'b0, HALF, -1);
        send_frame(8'h1C, 1'b0, 1'b0, HALF, -1);
        send_frame(8'h1C, 1'b0, 1'b0, HALF, -1);
        check_events("t2");

        send_frame(8'hE0, 1'b0, 1'b0, HALF, -1);
        send_frame(8'hF0, 1'b0, 1'b0, HALF, -1);
        send_frame(8'h75, 1'b0, 1'b0, HALF, -1);
        check_events("t3");

        send_frame(8'h1C, 1'b1, 1'b0, HALF, -1);
        send_frame(8'hF0, 1'b0, 1'b0, HALF, -1);
        send_frame(8'h44, 1'b0, 1'b1, HALF, -1);
        send_frame(8'h32, 1'b0, 1'b0, HALF, -1);
        check_events("t4");

        // start + 4 data bits, then the clock idles high until the frame times out
        send_frame(8'hF0, 1'b0, 1'b0, HALF, -1);
        send_partial(8'h1C, 5);
        repeat (100) @(negedge clk28);
        chk("to_busy_mid", 32'(busy), 32'h1);
        ev.err = 1'b1; ev.c = 8'h00; ev.e = 1'b0; ev.r = 1'b0;
        ev.t = last_fall + FILTER_LEN + 3 + TIMEOUT_CYCLES;
        exp_q.push_back(ev);
        n_err = n_err + 1;
        ext_m = 1'b0;
        rel_m = 1'b0;
        repeat (TIMEOUT_CYCLES) @(negedge clk28);
        chk("to_busy_after", 32'(busy), 32'h0);
        send_frame(8'h1C, 1'b0, 1'b0, HALF, -1);
        check_events("t5");

        // reset mid-frame after a pending F0
        send_frame(8'hF0, 1'b0, 1'b0, HALF, -1);
        send_partial(8'h5A, 4);
        apply_reset();
        chk_reset_state("midrst");
        rst_n = 1'b1;
        repeat (20) @(negedge clk28);
        chk_reset_state("midrst_rel");
        send_frame(8'h1C, 1'b0, 1'b0, HALF, -1);
        check_events("t5r");

        // short clock glitches in IDLE and inside a frame
        @(negedge clk28);
        ps2_clk_in = 1'b0;
        repeat (3) @(negedge clk28);
        ps2_clk_in = 1'b1;
        repeat (20) @(negedge clk28);
        chk("glitch_idle_busy", 32'(busy), 32'h0);
        send_frame(8'hE0, 1'b0, 1'b0, HALF, 4);
        send_frame(8'h6B, 1'b0, 1'b0, HALF, 7);
        check_events("t6");

        for (int k = 0; k < 30; k++) begin
            int pre;
            pre = $urandom_range(0, 3);
            if (pre == 1 || pre == 3) send_frame(8'hE0, 1'b0, 1'b0, HALF, -1);
            if (pre >= 2) send_frame(8'hF0, 1'b0, 1'b0, HALF, -1);
            send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0,
                       $urandom_range(0, 7) == 0, HALF, -1);
        end
        check_events("rnd");

`ifdef PS2_RX_ERRCNT_EN
        chk("errcnt_rnd", 32'(err_cnt), 32'((n_err > 255) ? 255 : n_err));
        // start-bit errors: one fall with data high while idle
        for (int k = 0; k < 300; k++) begin
            ps2_bit(1'b1, 14, 1'b0);
            model_frame(8'h00, 1'b0, last_fall);
        end
        check_events("errs");
        chk("errcnt_sat", 32'(err_cnt), 32'hFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
